lcd_cmd_sched: RTL and testbench



---
 rtl/lcd_pkg.sv | 30 +++
 rtl/lcd_cmd_fifo.sv | 52 +++++
 rtl/lcd_cmd_sched.sv | 121 ++++++++++++
 tb/tb_lcd_cmd_sched.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD command scheduler: engine command codes
// and the scheduler state encoding.
package lcd_pkg;

    localparam logic [3:0] CMD_WRITE   = 4'd0;
    localparam logic [3:0] CMD_UP      = 4'd1;
    localparam logic [3:0] CMD_DOWN    = 4'd2;
    localparam logic [3:0] CMD_LEFT    = 4'd3;
    localparam logic [3:0] CMD_RIGHT   = 4'd4;
    localparam logic [3:0] CMD_MAX     = 4'd5;
    localparam logic [3:0] CMD_MIN     = 4'd6;
    localparam logic [3:0] CMD_AVG     = 4'd7;
    localparam logic [3:0] CMD_WHITE   = 4'd8;
    localparam logic [3:0] CMD_BLACK   = 4'd9;
    localparam logic [3:0] CMD_ROTATE  = 4'd10;
    localparam logic [3:0] CMD_RESTORE = 4'd11;
    localparam logic [3:0] CMD_COPY    = 4'd12;
    localparam logic [3:0] CMD_PASTE   = 4'd13;
    localparam logic [3:0] CMD_NOP     = 4'd14;
    localparam logic [3:0] CMD_DONE    = 4'd15;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_WAIT_FREE = 3'd3,
        S_FINISH    = 3'd4
    } sched_state_t;

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Circular-buffer command FIFO with wrapping pointers and an occupancy
// counter. Pushes when full and pops when empty are ignored.
module lcd_cmd_fifo #(
    parameter int DEPTH = 8,
    parameter int LVL_W = $clog2(DEPTH) + 1,
    parameter int W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [W-1:0]     din,
    output logic [W-1:0]     dout,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage array; contents need no reset because level gates every read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (do_push && !do_pop)      level <= level + LVL_W'(1);
            else if (do_pop && !do_push) level <= level - LVL_W'(1);
        end
    end

endmodule

// File: rtl/lcd_cmd_sched.sv
// Buffers host commands and issues them one at a time to the LCD engine,
// holding the engine bus at NOP between issues. The engine is expected to
// raise busy on the cycle right after the issue cycle; anything else is
// flagged as a sticky error. Command 15 ends the session.
module lcd_cmd_sched
    import lcd_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic [3:0]       req_cmd,
    output logic             req_ready,
    output logic [3:0]       lcd_cmd,
    output logic             lcd_cmd_valid,
    input  logic             lcd_busy,
    input  logic             lcd_done,
    output logic [LVL_W-1:0] level,
    output logic [7:0]       issued_cnt,
    output logic             sched_done,
    output logic             err
);

    sched_state_t state, state_n;
    logic [3:0]   head;
    logic [3:0]   last_cmd, last_n;
    logic [3:0]   cmd_n;
    logic         valid_n;
    logic         full, empty;
    logic         term_seen;
    logic         accept;
    logic         push, pop;
    logic         cnt_inc, err_set, done_set;

    // Handshake: a NOP is consumed without being queued.
    assign req_ready = !full && !term_seen;
    assign accept    = req_valid && req_ready;
    assign push      = accept && (req_cmd != CMD_NOP);

    lcd_cmd_fifo #(.DEPTH(DEPTH), .LVL_W(LVL_W), .W(4)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (req_cmd),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    // Next-state and next-bus decode; the bus defaults to NOP every cycle.
    always_comb begin
        state_n  = state;
        last_n   = last_cmd;
        cmd_n    = CMD_NOP;
        valid_n  = 1'b0;
        pop      = 1'b0;
        cnt_inc  = 1'b0;
        err_set  = 1'b0;
        done_set = 1'b0;
        case (state)
            S_IDLE: begin
                if (!empty && !lcd_busy) begin
                    state_n = S_ISSUE;
                    cmd_n   = head;
                    valid_n = 1'b1;
                    pop     = 1'b1;
                    last_n  = head;
                end
            end
            S_ISSUE: begin
                state_n = S_WAIT_BUSY;
                cnt_inc = 1'b1;
            end
            S_WAIT_BUSY: begin
                if (last_cmd == CMD_DONE) begin
                    state_n = S_FINISH;
                end else if (lcd_busy) begin
                    state_n = S_WAIT_FREE;
                end else begin
                    err_set = 1'b1;
                    state_n = S_IDLE;
                end
            end
            S_WAIT_FREE: begin
                if (!lcd_busy) state_n = S_IDLE;
            end
            S_FINISH: begin
                if (lcd_done) done_set = 1'b1;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // State, registered engine bus, counters and sticky flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_IDLE;
            last_cmd      <= CMD_NOP;
            lcd_cmd       <= CMD_NOP;
            lcd_cmd_valid <= 1'b0;
            issued_cnt    <= 8'd0;
            sched_done    <= 1'b0;
            err           <= 1'b0;
            term_seen     <= 1'b0;
        end else begin
            state         <= state_n;
            last_cmd      <= last_n;
            lcd_cmd       <= cmd_n;
            lcd_cmd_valid <= valid_n;
            if (cnt_inc)  issued_cnt <= issued_cnt + 8'd1;
            if (done_set) sched_done <= 1'b1;
            if (err_set)  err        <= 1'b1;
            if (accept && (req_cmd == CMD_DONE)) term_seen <= 1'b1;
        end
    end

endmodule

// File: tb/tb_lcd_cmd_sched.sv
// Bench for lcd_cmd_sched: a behavioural engine model answers issues with a
// busy pulse, a host model records accepted commands into an expected queue,
// and each scenario compares the issued stream and status outputs.
module tb_lcd_cmd_sched;

    localparam int DEPTH = 8;
    localparam int LVL_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid;
    logic [3:0]       req_cmd;
    logic             req_ready;
    logic [3:0]       lcd_cmd;
    logic             lcd_cmd_valid;
    logic             lcd_busy;
    logic             lcd_done;
    logic [LVL_W-1:0] level;
    logic [7:0]       issued_cnt;
    logic             sched_done;
    logic             err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0] exp_q[$];
    logic [3:0] obs_q[$];
    bit         m_term;

    bit         eng_auto;
    bit         ignore_8;
    int         op_len;
    int         eng_cnt;
    bit         s_valid;
    logic [3:0] s_cmd;

    lcd_cmd_sched #(.DEPTH(DEPTH), .LVL_W(LVL_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_cmd       (req_cmd),
        .req_ready     (req_ready),
        .lcd_cmd       (lcd_cmd),
        .lcd_cmd_valid (lcd_cmd_valid),
        .lcd_busy      (lcd_busy),
        .lcd_done      (lcd_done),
        .level         (level),
        .issued_cnt    (issued_cnt),
        .sched_done    (sched_done),
        .err           (err)
    );

    // Clock
    always #5 clk = ~clk;

    // Engine model: records every issue seen on the bus; in auto mode it
    // answers an issue with busy for op_len cycles starting the next cycle.
    initial begin
        forever begin
            @(negedge clk);
            s_valid = lcd_cmd_valid && rst;
            s_cmd   = lcd_cmd;
            @(posedge clk);
            #1;
            if (s_valid) obs_q.push_back(s_cmd);
            if (eng_auto) begin
                if (eng_cnt > 0) begin
                    eng_cnt--;
                    if (eng_cnt == 0) lcd_busy = 1'b0;
                end else if (s_valid && !(ignore_8 && s_cmd == 4'd8)) begin
                    lcd_busy = 1'b1;
                    eng_cnt  = op_len;
                end
            end
        end
    end

    // Host-side reference: what the scheduler must eventually issue.
    function automatic void model_accept(input logic [3:0] c);
        if (!m_term) begin
            if (c != 4'hE) exp_q.push_back(c);
            if (c == 4'hF) m_term = 1'b1;
        end
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b0;
        eng_auto  = 1'b0;
        ignore_8  = 1'b0;
        eng_cnt   = 0;
        lcd_busy  = 1'b0;
        lcd_done  = 1'b0;
        req_valid = 1'b0;
        req_cmd   = 4'h0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        obs_q.delete();
        m_term = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Offers one command until accepted (bounded); returns whether it went in.
    task automatic push_cmd(input logic [3:0] c, output bit ok);
        ok        = 1'b0;
        req_valid = 1'b1;
        req_cmd   = c;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
                model_accept(c);
            end
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
    endtask

    task automatic wait_issued(input int n);
        for (int i = 0; i < 5000 && obs_q.size() < n; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got %b want 1", req_ready); end
        n_tests++; if (lcd_cmd !== 4'hE) begin n_fail++; $display("FAIL rst_cmd got %h want e", lcd_cmd); end
        n_tests++; if (lcd_cmd_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b want 0", lcd_cmd_valid); end
        n_tests++; if (level !== 4'd0) begin n_fail++; $display("FAIL rst_level got %0d want 0", level); end
        n_tests++; if (issued_cnt !== 8'd0) begin n_fail++; $display("FAIL rst_cnt got %0d want 0", issued_cnt); end
        n_tests++; if (sched_done !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL rst_flags got done=%b err=%b want 0 0", sched_done, err); end
    endtask

    task automatic test_startup();
        bit ok;
        do_reset();
        lcd_busy = 1'b1;
        push_cmd(4'd5, ok);
        repeat (70) @(posedge clk);
        @(negedge clk);
        n_tests++; if (!ok || lcd_cmd !== 4'hE || lcd_cmd_valid !== 1'b0 || level !== 4'd1) begin
            n_fail++; $display("FAIL startup_hold got ok=%b cmd=%h v=%b lvl=%0d want 1 e 0 1", ok, lcd_cmd, lcd_cmd_valid, level);
        end
        @(posedge clk); #1;
        lcd_busy = 1'b0;
        @(negedge clk);
        n_tests++; if (lcd_cmd_valid !== 1'b0) begin n_fail++; $display("FAIL startup_early got v=%b want 0", lcd_cmd_valid); end
        @(negedge clk);
        n_tests++; if (lcd_cmd !== 4'd5 || lcd_cmd_valid !== 1'b1) begin
            n_fail++; $display("FAIL startup_issue got cmd=%h v=%b want 5 1", lcd_cmd, lcd_cmd_valid);
        end
        @(posedge clk); #1;
        lcd_busy = 1'b1;
        @(negedge clk);
        n_tests++; if (lcd_cmd !== 4'hE || lcd_cmd_valid !== 1'b0 || issued_cnt !== 8'd1) begin
            n_fail++; $display("FAIL startup_after got cmd=%h v=%b cnt=%0d want e 0 1", lcd_cmd, lcd_cmd_valid, issued_cnt);
        end
        repeat (4) @(posedge clk);
        #1;
        lcd_busy = 1'b0;
        repeat (4) @(negedge clk);
        n_tests++; if (err !== 1'b0 || obs_q.size() !== 1) begin
            n_fail++; $display("FAIL startup_end got err=%b issues=%0d want 0 1", err, obs_q.size());
        end
    endtask

    task automatic test_full_fifo();
        bit ok;
        int acc = 0;
        bit saw_ready = 1'b0;
        do_reset();
        lcd_busy = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            push_cmd(4'(i), ok);
            if (ok) acc++;
        end
        @(negedge clk);
        n_tests++; if (acc !== 8 || level !== 4'd8 || req_ready !== 1'b0) begin
            n_fail++; $display("FAIL full_state got acc=%0d lvl=%0d rdy=%b want 8 8 0", acc, level, req_ready);
        end
        req_valid = 1'b1;
        req_cmd   = 4'd9;
        repeat (5) begin
            @(negedge clk);
            if (req_ready) saw_ready = 1'b1;
        end
        n_tests++; if (saw_ready !== 1'b0 || level !== 4'd8) begin
            n_fail++; $display("FAIL full_hold got rdy_seen=%b lvl=%0d want 0 8", saw_ready, level);
        end
        op_len   = $urandom_range(1, 6);
        lcd_busy = 1'b0;
        eng_auto = 1'b1;
        push_cmd(4'd9, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL full_ninth got accepted=0 want 1"); end
        wait_issued(9);
        repeat (20) @(negedge clk);
        n_tests++; if (obs_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL full_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_tests++; if (obs_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL full_order[%0d] got %0d want %0d", i, obs_q[i], exp_q[i]);
            end
        end
        n_tests++; if (issued_cnt !== 8'd9 || level !== 4'd0 || err !== 1'b0) begin
            n_fail++; $display("FAIL full_end got cnt=%0d lvl=%0d err=%b want 9 0 0", issued_cnt, level, err);
        end
    endtask

    task automatic test_nop_drop();
        bit ok;
        do_reset();
        lcd_busy = 1'b1;
        push_cmd(4'hE, ok);
        push_cmd(4'd7, ok);
        @(negedge clk);
        n_tests++; if (level !== 4'd1) begin n_fail++; $display("FAIL nop_level got %0d want 1", level); end
        op_len   = $urandom_range(1, 6);
        lcd_busy = 1'b0;
        eng_auto = 1'b1;
        wait_issued(1);
        repeat (20) @(negedge clk);
        n_tests++; if (obs_q.size() !== 1 || exp_q.size() !== 1) begin
            n_fail++; $display("FAIL nop_count got %0d want 1", obs_q.size());
        end else begin
            n_tests++; if (obs_q[0] !== exp_q[0]) begin n_fail++; $display("FAIL nop_cmd got %0d want %0d", obs_q[0], exp_q[0]); end
        end
        n_tests++; if (issued_cnt !== 8'd1) begin n_fail++; $display("FAIL nop_cnt got %0d want 1", issued_cnt); end
    endtask

    task automatic test_terminal();
        bit ok;
        bit saw_ready = 1'b0;
        do_reset();
        op_len   = 3;
        eng_auto = 1'b1;
        push_cmd(4'hF, ok);
        @(negedge clk);
        n_tests++; if (!ok || req_ready !== 1'b0) begin n_fail++; $display("FAIL term_ready got ok=%b rdy=%b want 1 0", ok, req_ready); end
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_cmd   = 4'd3;
        repeat (20) begin
            @(negedge clk);
            if (req_ready) begin saw_ready = 1'b1; model_accept(4'd3); end
        end
        req_valid = 1'b0;
        n_tests++; if (saw_ready !== 1'b0 || level !== 4'd0) begin
            n_fail++; $display("FAIL term_block got rdy_seen=%b lvl=%0d want 0 0", saw_ready, level);
        end
        n_tests++; if (sched_done !== 1'b0) begin n_fail++; $display("FAIL term_early_done got %b want 0", sched_done); end
        @(posedge clk); #1;
        lcd_done = 1'b1;
        @(posedge clk); #1;
        lcd_done = 1'b0;
        @(negedge clk);
        n_tests++; if (sched_done !== 1'b1) begin n_fail++; $display("FAIL term_done got %b want 1", sched_done); end
        repeat (10) @(negedge clk);
        n_tests++; if (sched_done !== 1'b1 || obs_q.size() !== exp_q.size() || issued_cnt !== 8'd1) begin
            n_fail++; $display("FAIL term_end got done=%b issues=%0d want 1 %0d cnt=%0d", sched_done, obs_q.size(), exp_q.size(), issued_cnt);
        end else begin
            n_tests++; if (obs_q[0] !== 4'hF) begin n_fail++; $display("FAIL term_cmd got %0d want 15", obs_q[0]); end
        end
    endtask

    task automatic test_error();
        bit ok;
        do_reset();
        op_len   = $urandom_range(1, 6);
        ignore_8 = 1'b1;
        eng_auto = 1'b1;
        push_cmd(4'd8, ok);
        push_cmd(4'd2, ok);
        wait_issued(2);
        repeat (20) @(negedge clk);
        n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_flag got %b want 1", err); end
        n_tests++; if (obs_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL err_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_tests++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL err_order[%0d] got %0d want %0d", i, obs_q[i], exp_q[i]); end
        end
        n_tests++; if (issued_cnt !== 8'd2) begin n_fail++; $display("FAIL err_cnt got %0d want 2", issued_cnt); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int t;
        do_reset();
        op_len   = 20;
        eng_auto = 1'b1;
        for (int i = 1; i <= 4; i++) push_cmd(4'(i), ok);
        t = 0;
        while (!lcd_busy && t < 50) begin @(negedge clk); t++; end
        repeat (3) @(negedge clk);
        n_tests++; if (level !== 4'd3 || issued_cnt !== 8'd1 || lcd_busy !== 1'b1) begin
            n_fail++; $display("FAIL mid_before got lvl=%0d cnt=%0d busy=%b want 3 1 1", level, issued_cnt, lcd_busy);
        end
        rst = 1'b0;
        #1;
        n_tests++; if (level !== 4'd0 || lcd_cmd !== 4'hE || issued_cnt !== 8'd0 || req_ready !== 1'b1) begin
            n_fail++; $display("FAIL mid_reset got lvl=%0d cmd=%h cnt=%0d rdy=%b want 0 e 0 1", level, lcd_cmd, issued_cnt, req_ready);
        end
        eng_auto = 1'b0;
        eng_cnt  = 0;
        lcd_busy = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        n_tests++; if (lcd_cmd_valid !== 1'b0 || level !== 4'd0) begin
            n_fail++; $display("FAIL mid_after got v=%b lvl=%0d want 0 0", lcd_cmd_valid, level);
        end
    endtask

    task automatic test_random(input int n_cmds, input int max_op);
        bit ok;
        int acc = 0;
        do_reset();
        eng_auto = 1'b1;
        for (int i = 0; i < n_cmds; i++) begin
            op_len = $urandom_range(1, max_op);
            push_cmd(4'($urandom_range(0, 14)), ok);
            if (ok) acc++;
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        wait_issued(exp_q.size());
        repeat (40) @(negedge clk);
        n_tests++; if (acc !== n_cmds) begin n_fail++; $display("FAIL rand_accept got %0d want %0d", acc, n_cmds); end
        n_tests++; if (obs_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL rand_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_tests++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_order[%0d] got %0d want %0d", i, obs_q[i], exp_q[i]); end
        end
        n_tests++; if (issued_cnt !== 8'(exp_q.size()) || err !== 1'b0 || level !== 4'd0) begin
            n_fail++; $display("FAIL rand_end got cnt=%0d err=%b lvl=%0d want %0d 0 0", issued_cnt, err, level, exp_q.size());
        end
    endtask

    initial begin
        rst       = 1'b0;
        req_valid = 1'b0;
        req_cmd   = 4'h0;
        lcd_busy  = 1'b0;
        lcd_done  = 1'b0;
        eng_auto  = 1'b0;
        ignore_8  = 1'b0;
        op_len    = 1;
        eng_cnt   = 0;
        m_term    = 1'b0;
        test_reset();
        test_startup();
        test_full_fifo();
        test_nop_drop();
        test_terminal();
        test_error();
        test_reset_mid();
        test_random(24, 5);
        test_random(30, 1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
